// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared pipeline definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding, datapath width and small decode helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int WIDTH = 32;

   // Operation codes presented on the op bus alongside start
   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdState_t;

   // True for the four iterative operations that occupy the unit
   function automatic logic isMdOp(input logic [2:0] opCode);
      return (opCode == MD_MULT) || (opCode == MD_MULTU) ||
             (opCode == MD_DIV)  || (opCode == MD_DIVU);
   endfunction

   // True for the two divide flavours
   function automatic logic isDivOp(input logic [2:0] opCode);
      return (opCode == MD_DIV) || (opCode == MD_DIVU);
   endfunction

   // True for the operations whose operands are two's complement
   function automatic logic isSignedOp(input logic [2:0] opCode);
      return (opCode == MD_MULT) || (opCode == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Purely combinational sign correction applied to the raw unsigned result of
// the iterative core before it is written to HI/LO.
// Ports:
//   raw    - unsigned core result: product, or {remainder, quotient}
//   signA  - sign of the first operand (0 for unsigned ops)
//   signB  - sign of the second operand (0 for unsigned ops)
//   op     - operation that produced raw
//   hiFix  - corrected HI value
//   loFix  - corrected LO value
// -----------------------------------------------------------------------------
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [2*W-1:0] raw,
   input  logic           signA,
   input  logic           signB,
   input  logic [2:0]     op,
   output logic [W-1:0]   hiFix,
   output logic [W-1:0]   loFix
);

   logic [2*W-1:0] prodNeg;
   logic [W-1:0]   quoNeg;
   logic [W-1:0]   remNeg;

   // Two's complement negations of the full product and of each half
   always_comb begin
      prodNeg = ~raw + {{(2*W-1){1'b0}}, 1'b1};
      quoNeg  = ~raw[W-1:0] + {{(W-1){1'b0}}, 1'b1};
      remNeg  = ~raw[2*W-1:W] + {{(W-1){1'b0}}, 1'b1};
   end

   // Select corrected halves; the remainder follows the dividend's sign
   always_comb begin
      hiFix = raw[2*W-1:W];
      loFix = raw[W-1:0];
      case (op)
         MD_MULT: begin
            if (signA ^ signB) begin
               {hiFix, loFix} = prodNeg;
            end else begin
               {hiFix, loFix} = raw;
            end
         end
         MD_DIV: begin
            if (signA ^ signB) begin
               loFix = quoNeg;
            end else begin
               loFix = raw[W-1:0];
            end
            if (signA) begin
               hiFix = remNeg;
            end else begin
               hiFix = raw[2*W-1:W];
            end
         end
         default: begin
            hiFix = raw[2*W-1:W];
            loFix = raw[W-1:0];
         end
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit in the execute stage. Owns the architectural
// HI/LO registers. Mult/div take one issue edge, ITER iteration edges and one
// sign-fix edge; MTHI/MTLO write in a single cycle when the unit is idle.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - issue the op on the current EX cycle
//   op       - operation code (muldiv_pkg MD_*)
//   busA     - first operand (rs)
//   busB     - second operand (rt)
//   kill     - pipeline flush, aborts any in-flight op
//   rd_hilo  - MFHI/MFLO present in EX
//   hi, lo   - HI/LO registers
//   busy     - registered, high while an op is in flight
//   stall    - combinational hold request to the hazard logic
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = muldiv_pkg::WIDTH,
   parameter int ITER  = 32  // must equal WIDTH: one quotient/product bit per edge
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             kill,
   input  logic             rd_hilo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall
);

   localparam int W  = WIDTH;
   localparam int CW = $clog2(ITER);

   mdState_t          stateR;
   mdState_t          stateNext;
   logic [CW-1:0]     counterR;
   logic [2*W-1:0]    prodR;      // product, or {remainder, dividend/quotient}
   logic [W-1:0]      opBR;       // multiplicand / divisor magnitude
   logic [2:0]        opR;
   logic              signAR;
   logic              signBR;
   logic              busyR;
   logic [W-1:0]      hiR;
   logic [W-1:0]      loR;

   logic              idleS;
   logic              issueMdS;
   logic              mtHiS;
   logic              mtLoS;
   logic              fixWriteS;
   logic [W-1:0]      magAS;
   logic [W-1:0]      magBS;
   logic [W:0]        mulSumS;
   logic [W:0]        divShiftS;
   logic [W:0]        divTrialS;
   logic [2*W-1:0]    stepNextS;
   logic [W-1:0]      fixHiS;
   logic [W-1:0]      fixLoS;

   // Issue decode; kill suppresses every kind of issue on the same edge
   always_comb begin
      idleS     = (stateR == IDLE);
      issueMdS  = start & ~kill & idleS & isMdOp(op);
      mtHiS     = start & ~kill & idleS & (op == MD_MTHI);
      mtLoS     = start & ~kill & idleS & (op == MD_MTLO);
      fixWriteS = (stateR == FIX) & ~kill;
   end

   // Operand magnitudes; only signed ops fold negative values
   always_comb begin
      if (isSignedOp(op) && busA[W-1]) begin
         magAS = ~busA + {{(W-1){1'b0}}, 1'b1};
      end else begin
         magAS = busA;
      end
      if (isSignedOp(op) && busB[W-1]) begin
         magBS = ~busB + {{(W-1){1'b0}}, 1'b1};
      end else begin
         magBS = busB;
      end
   end

   // One iteration step: shift-add multiply or restoring divide
   always_comb begin
      mulSumS   = {1'b0, prodR[2*W-1:W]} + (prodR[0] ? {1'b0, opBR} : {(W+1){1'b0}});
      divShiftS = {prodR[2*W-1:W], prodR[W-1]};
      divTrialS = divShiftS - {1'b0, opBR};
      if (isDivOp(opR)) begin
         if (divTrialS[W]) begin
            stepNextS = {divShiftS[W-1:0], prodR[W-2:0], 1'b0};
         end else begin
            stepNextS = {divTrialS[W-1:0], prodR[W-2:0], 1'b1};
         end
      end else begin
         // Product bits leave the bottom as the accumulator shifts in from the top
         stepNextS = {mulSumS, prodR[W-1:1]};
      end
   end

   muldiv_signfix #(.W(W)) uSignfix (
      .raw   (prodR),
      .signA (signAR),
      .signB (signBR),
      .op    (opR),
      .hiFix (fixHiS),
      .loFix (fixLoS)
   );

   // FSM next-state logic
   always_comb begin
      stateNext = stateR;
      case (stateR)
         IDLE: begin
            if (issueMdS) begin
               stateNext = RUN;
            end else begin
               stateNext = IDLE;
            end
         end
         RUN: begin
            if (kill) begin
               stateNext = IDLE;
            end else if (counterR == {CW{1'b0}}) begin
               stateNext = FIX;
            end else begin
               stateNext = RUN;
            end
         end
         FIX: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // FSM state and busy flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateR <= IDLE;
         busyR  <= 1'b0;
      end else begin
         stateR <= stateNext;
         busyR  <= (stateNext != IDLE);
      end
   end

   // Iteration datapath: operand capture on issue, one step per RUN edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prodR    <= {(2*W){1'b0}};
         opBR     <= {W{1'b0}};
         opR      <= MD_MULT;
         signAR   <= 1'b0;
         signBR   <= 1'b0;
         counterR <= {CW{1'b0}};
      end else begin
         case (stateR)
            IDLE: begin
               if (issueMdS) begin
                  prodR    <= {{W{1'b0}}, magAS};
                  opBR     <= magBS;
                  opR      <= op;
                  signAR   <= isSignedOp(op) & busA[W-1];
                  signBR   <= isSignedOp(op) & busB[W-1];
                  counterR <= CW'(ITER - 1);
               end
            end
            RUN: begin
               if (!kill) begin
                  prodR    <= stepNextS;
                  counterR <= counterR - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               counterR <= counterR;
            end
         endcase
      end
   end

   // Architectural HI/LO: sign-fixed result or MTHI/MTLO move
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hiR <= {W{1'b0}};
         loR <= {W{1'b0}};
      end else if (fixWriteS) begin
         hiR <= fixHiS;
         loR <= fixLoS;
      end else begin
         if (mtHiS) begin
            hiR <= busA;
         end
         if (mtLoS) begin
            loR <= busA;
         end
      end
   end

   assign hi    = hiR;
   assign lo    = loR;
   assign busy  = busyR;
   assign stall = busyR & (start | rd_hilo);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        kill;
   logic        rd_hilo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .busA    (busA),
      .busB    (busB),
      .kill    (kill),
      .rd_hilo (rd_hilo),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .stall   (stall)
   );

   // Reference model: {hi, lo} from plain arithmetic
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = 64'd0;
      case (o)
         MD_MULT:  res = sa * sb;
         MD_MULTU: res = {32'd0, a} * {32'd0, b};
         MD_DIV: begin
            if (b == 32'd0) res = {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         MD_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a mult/div, count busy cycles and check the result
   task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      int n;
      e = model(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; busA = a; busB = b;
      @(posedge clk);
      #1;
      start = 1'b0; busA = $urandom; busB = $urandom;
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 60) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busycyc"}, 64'(n), 64'd33);
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
   endtask

   task automatic moveTo(input logic [2:0] o, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1; op = o; busA = v;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      logic [63:0] e;
      logic [31:0] a, b, prevHi, prevLo;
      logic [2:0]  ro;
      int n;
      logic bad;

      rst = 1'b1; start = 1'b0; op = 3'd0; busA = 32'd0; busB = 32'd0;
      kill = 1'b0; rd_hilo = 1'b0;
      #12;
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed operations from the plan
      runOp("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2);
      runOp("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      runOp("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
      runOp("divu", MD_DIVU, 32'd100, 32'd7);
      runOp("divu_z", MD_DIVU, 32'd5, 32'd0);
      runOp("div_z", MD_DIV, 32'd5, 32'd0);
      runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000);

      // Randomized operations against the model
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
         runOp("rand", ro, a, b);
      end

      // rd_hilo during a MULT: stall until busy falls, no early update
      prevHi = hi; prevLo = lo;
      a = 32'h1234_5678; b = 32'hFEDC_BA98;
      e = model(MD_MULT, a, b);
      @(negedge clk);
      start = 1'b1; op = MD_MULT; busA = a; busB = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rd_hilo = 1'b1;
      bad = 1'b0; n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 60) begin
         if (stall !== 1'b1 || hi !== prevHi || lo !== prevLo) bad = 1'b1;
         n++;
         @(negedge clk);
      end
      check("rdhilo_stall_held", {63'd0, bad}, 64'd0);
      check("rdhilo_cycles", 64'(n), 64'd29);
      check("rdhilo_stall_rel", {63'd0, stall}, 64'd0);
      check("rdhilo_hi", {32'd0, hi}, {32'd0, e[63:32]});
      check("rdhilo_lo", {32'd0, lo}, {32'd0, e[31:0]});
      rd_hilo = 1'b0;

      // MTLO presented while busy: stalled, then lands at the first idle edge
      prevLo = lo;
      a = 32'd3; b = 32'hFFFF_FFFB;
      e = model(MD_MULT, a, b);
      @(negedge clk);
      start = 1'b1; op = MD_MULT; busA = a; busB = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; op = MD_MTLO; busA = 32'h0000_1234;
      bad = 1'b0; n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 60) begin
         if (stall !== 1'b1 || lo !== prevLo) bad = 1'b1;
         n++;
         @(negedge clk);
      end
      check("mtlo_stalled", {63'd0, bad}, 64'd0);
      check("mtlo_mult_lo", {32'd0, lo}, {32'd0, e[31:0]});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("mtlo_lo", {32'd0, lo}, 64'h1234);
      check("mtlo_hi", {32'd0, hi}, {32'd0, e[63:32]});
      check("mtlo_busy", {63'd0, busy}, 64'd0);

      // Preload HI/LO
      moveTo(MD_MTHI, 32'h0000_00AA);
      moveTo(MD_MTLO, 32'h0000_00BB);
      check("pre_hi", {32'd0, hi}, 64'hAA);
      check("pre_lo", {32'd0, lo}, 64'hBB);

      // Undefined op codes have no effect
      moveTo(3'b110, 32'h5555_5555);
      moveTo(3'b111, 32'h6666_6666);
      check("undef_busy", {63'd0, busy}, 64'd0);
      check("undef_hi", {32'd0, hi}, 64'hAA);
      check("undef_lo", {32'd0, lo}, 64'hBB);

      // kill together with start: no issue
      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = MD_MTHI; busA = 32'h77;
      @(posedge clk);
      #1;
      op = MD_DIV; busB = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0; kill = 1'b0;
      check("killstart_hi", {32'd0, hi}, 64'hAA);
      check("killstart_busy", {63'd0, busy}, 64'd0);

      // kill at E10 of a DIV
      @(negedge clk);
      start = 1'b1; op = MD_DIV; busA = 32'd1000; busB = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("kill_busy_before", {63'd0, busy}, 64'd1);
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_busy", {63'd0, busy}, 64'd0);
      check("kill_hi", {32'd0, hi}, 64'hAA);
      check("kill_lo", {32'd0, lo}, 64'hBB);
      repeat (40) @(negedge clk);
      check("kill_late_hi", {32'd0, hi}, 64'hAA);
      check("kill_late_lo", {32'd0, lo}, 64'hBB);
      check("kill_late_busy", {63'd0, busy}, 64'd0);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      start = 1'b1; op = MD_MULT; busA = 32'd7; busB = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("arst_busy_before", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_hi", {32'd0, hi}, 64'd0);
      check("arst_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Unit still operational after reset
      runOp("post_rst", MD_DIVU, 32'hFFFF_FFFF, 32'd16);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
